// File: rtl/hazard_fwd_unit_if.sv
// rtl/hazard_fwd_unit_if.sv - ID/EX hazard and forwarding controller signal bundle
interface hazard_fwd_unit_if #(
    parameter int FWD_DEPTH = 2
);
    localparam int SELW = $clog2(2 * FWD_DEPTH + 1);

    logic            pipe_en;
    logic [31:0]     inst_id;
    logic            id_valid;
    logic            breq;
    logic            brlt;
    logic [31:0]     inst_ex;
    logic            brun;
    logic [SELW-1:0] rs1_sel;
    logic [SELW-1:0] rs2_sel;
    logic            pc_sel_ex;
    logic            stall;
    logic            flush;
    logic [31:0]     stall_cnt;
    logic [31:0]     flush_cnt;

    modport master (
        output pipe_en, inst_id, id_valid, breq, brlt,
        input  inst_ex, brun, rs1_sel, rs2_sel, pc_sel_ex, stall, flush,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  pipe_en, inst_id, id_valid, breq, brlt,
        output inst_ex, brun, rs1_sel, rs2_sel, pc_sel_ex, stall, flush,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - hazard/forwarding/redirect controller; HAZARD_PERF_EN adds stall/flush counters
module hazard_fwd_unit #(
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    localparam int SELW     = $clog2(2 * FWD_DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    hazard_fwd_unit_if.slave      io_hz
);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [6:0]  OP_LUI  = 7'b0110111;
    localparam logic [6:0]  OP_AUI  = 7'b0010111;
    localparam logic [6:0]  OP_JAL  = 7'b1101111;
    localparam logic [6:0]  OP_JALR = 7'b1100111;
    localparam logic [6:0]  OP_BR   = 7'b1100011;
    localparam logic [6:0]  OP_LD   = 7'b0000011;
    localparam logic [6:0]  OP_ST   = 7'b0100011;
    localparam logic [6:0]  OP_R    = 7'b0110011;
    localparam logic [6:0]  OP_SYS  = 7'b1110011;

    function automatic logic f_writes_rd(input logic [31:0] inst);
        return (inst[6:0] != OP_ST) && (inst[6:0] != OP_BR) &&
               (inst[6:0] != OP_SYS) && (inst[11:7] != 5'd0);
    endfunction

    function automatic logic f_uses_rs1(input logic [31:0] inst);
        return (inst[6:0] != OP_LUI) && (inst[6:0] != OP_AUI) && (inst[6:0] != OP_JAL);
    endfunction

    function automatic logic f_uses_rs2(input logic [31:0] inst);
        return (inst[6:0] == OP_R) || (inst[6:0] == OP_ST) || (inst[6:0] == OP_BR);
    endfunction

    logic [31:0]        r_inst_ex;
    logic [FWD_DEPTH:1] r_sb_valid;
    logic [FWD_DEPTH:1] r_sb_load;
    logic [4:0]         r_sb_rd [1:FWD_DEPTH];

    logic [FWD_DEPTH:0] w_valid;
    logic [FWD_DEPTH:0] w_load;
    logic [4:0]         w_rd [0:FWD_DEPTH];
    logic [SELW-1:0]    w_rs1_sel;
    logic [SELW-1:0]    w_rs2_sel;
    logic               w_raw;
    logic               w_taken;
    logic               w_pc_sel;
    logic               w_stall;
    logic               w_id_rs1;
    logic               w_id_rs2;

    // Scoreboard view: entry 0 decoded live from EX, older entries from flops
    always_comb begin
        w_valid[0] = f_writes_rd(r_inst_ex);
        w_load[0]  = (r_inst_ex[6:0] == OP_LD);
        w_rd[0]    = r_inst_ex[11:7];
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            w_valid[k] = r_sb_valid[k];
            w_load[k]  = r_sb_load[k];
            w_rd[k]    = r_sb_rd[k];
        end
    end

    // Bypass selects: scan oldest to youngest so the youngest match overrides
    always_comb begin
        w_rs1_sel = '0;
        w_rs2_sel = '0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (f_uses_rs1(r_inst_ex) && (r_inst_ex[19:15] != 5'd0) &&
                w_valid[k] && (w_rd[k] == r_inst_ex[19:15]))
                w_rs1_sel = w_load[k] ? SELW'(2 * k) : SELW'(2 * k - 1);
            if (f_uses_rs2(r_inst_ex) && (r_inst_ex[24:20] != 5'd0) &&
                w_valid[k] && (w_rd[k] == r_inst_ex[24:20]))
                w_rs2_sel = w_load[k] ? SELW'(2 * k) : SELW'(2 * k - 1);
        end
    end

    // Load-use detect: ID operand needs a load that is not yet forwardable next cycle
    always_comb begin
        w_id_rs1 = io_hz.id_valid && f_uses_rs1(io_hz.inst_id) && (io_hz.inst_id[19:15] != 5'd0);
        w_id_rs2 = io_hz.id_valid && f_uses_rs2(io_hz.inst_id) && (io_hz.inst_id[24:20] != 5'd0);
        w_raw    = 1'b0;
        for (int j = 0; j < FWD_DEPTH; j++) begin
            if ((j + 1 < LOAD_LAT) && w_valid[j] && w_load[j] &&
                ((w_id_rs1 && (w_rd[j] == io_hz.inst_id[19:15])) ||
                 (w_id_rs2 && (w_rd[j] == io_hz.inst_id[24:20]))))
                w_raw = 1'b1;
        end
    end

    // Branch resolution and redirect; a redirect kills ID so it overrides the stall
    always_comb begin
        w_taken = 1'b0;
        case (r_inst_ex[14:12])
            3'b000:          w_taken = io_hz.breq;
            3'b001:          w_taken = !io_hz.breq;
            3'b100, 3'b110:  w_taken = io_hz.brlt;
            3'b101, 3'b111:  w_taken = !io_hz.brlt;
            default:         w_taken = 1'b0;
        endcase
        w_pc_sel = (r_inst_ex[6:0] == OP_JAL) || (r_inst_ex[6:0] == OP_JALR) ||
                   ((r_inst_ex[6:0] == OP_BR) && w_taken);
        w_stall  = w_raw && !w_pc_sel;
    end

    // EX instruction register and scoreboard shift
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inst_ex  <= NOP;
            r_sb_valid <= '0;
            r_sb_load  <= '0;
            for (int k = 1; k <= FWD_DEPTH; k++) r_sb_rd[k] <= 5'd0;
        end else if (io_hz.pipe_en) begin
            if (w_pc_sel || w_stall)  r_inst_ex <= NOP;
            else if (io_hz.id_valid)  r_inst_ex <= io_hz.inst_id;
            else                      r_inst_ex <= NOP;
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                r_sb_valid[k] <= w_valid[k-1];
                r_sb_load[k]  <= w_load[k-1];
                r_sb_rd[k]    <= w_rd[k-1];
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating stall/flush event counters, frozen while the pipe is held
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (io_hz.pipe_en) begin
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_pc_sel && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign io_hz.stall_cnt = r_stall_cnt;
    assign io_hz.flush_cnt = r_flush_cnt;
`else
    assign io_hz.stall_cnt = 32'd0;
    assign io_hz.flush_cnt = 32'd0;
`endif

    assign io_hz.inst_ex   = r_inst_ex;
    assign io_hz.brun      = (r_inst_ex[6:0] == OP_BR) && r_inst_ex[14:13] == 2'b11;
    assign io_hz.rs1_sel   = w_rs1_sel;
    assign io_hz.rs2_sel   = w_rs2_sel;
    assign io_hz.pc_sel_ex = w_pc_sel;
    assign io_hz.flush     = w_pc_sel;
    assign io_hz.stall     = w_stall;
endmodule
